// File: rtl/sd_cmd_responder.sv
// sd_cmd_responder: card-side SD CMD-line engine.
// Receives 48-bit host commands, checks framing (and optionally CRC7),
// hands index/argument to card logic, then sends the 48-bit response
// after the NCR gap.
// Build option: define SD_CMD_CRC_CHECK_EN to verify the command CRC7;
// without it the CRC field is captured but ignored and CrcError stays 0.
module sd_cmd_responder #(
  parameter int NCR_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CmdIn,
  output logic        CmdOut,
  output logic        CmdOutEn,
  output logic        CmdValid,
  input  logic        CmdReady,
  output logic [5:0]  CmdIndex,
  output logic [31:0] CmdArg,
  input  logic        RspValid,
  output logic        RspReady,
  input  logic        RspNone,
  input  logic        RspNoCrc,
  input  logic [5:0]  RspIndex,
  input  logic [31:0] RspArg,
  output logic        CrcError,
  output logic        FrameError,
  output logic        Busy
);

`ifdef SD_CMD_CRC_CHECK_EN
  localparam bit CRC_CHECK = 1'b1;
`else
  localparam bit CRC_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RECV, DELIVER, WAITRSP, GAP, SEND} state_t;

  state_t      state;
  logic [46:0] sr;       // bits received so far, newest in lsb
  logic [5:0]  bitcnt;   // bits captured so far in the current frame
  logic [6:0]  crc;      // running command CRC7
  logic [6:0]  ncr_cnt;  // cycles since end bit, saturating
  logic [47:0] tx;       // response frame, shifted out msb first
  logic [5:0]  txcnt;

  // One CRC7 step, polynomial x^7 + x^3 + 1
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  logic [39:0] rsp_hdr;
  logic [6:0]  rsp_crc;
  assign rsp_hdr = {2'b00, RspIndex, RspArg};
  // R3 carries all-ones in place of a CRC
  assign rsp_crc = RspNoCrc ? 7'h7F : crc7_40(rsp_hdr);

  assign Busy = (state != IDLE);

  // Command receive, handshakes, NCR gap and response transmit
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      sr         <= '0;
      bitcnt     <= '0;
      crc        <= '0;
      ncr_cnt    <= '0;
      tx         <= '1;
      txcnt      <= '0;
      CmdOut     <= 1'b1;
      CmdOutEn   <= 1'b0;
      CmdValid   <= 1'b0;
      RspReady   <= 1'b0;
      CmdIndex   <= '0;
      CmdArg     <= '0;
      CrcError   <= 1'b0;
      FrameError <= 1'b0;
    end else begin
      CrcError   <= 1'b0;
      FrameError <= 1'b0;
      if (ncr_cnt != 7'h7F) ncr_cnt <= ncr_cnt + 7'd1;
      case (state)
        IDLE: begin
          if (!CmdIn) begin
            state  <= RECV;
            bitcnt <= 6'd1;
            sr     <= '0;     // start bit already in lsb
            crc    <= 7'h00;  // CRC of a single 0 bit is 0
          end
        end
        RECV: begin
          sr     <= {sr[45:0], CmdIn};
          bitcnt <= bitcnt + 6'd1;
          if (bitcnt < 6'd40) crc <= crc7_step(crc, CmdIn);
          if (bitcnt == 6'd47) begin
            // CmdIn is the end bit; sr[45] is the transmission bit
            ncr_cnt <= '0;
            state   <= IDLE;
            if (!sr[45] || !CmdIn) FrameError <= 1'b1;
            else if (CRC_CHECK && (crc != sr[6:0])) CrcError <= 1'b1;
            else begin
              CmdIndex <= sr[44:39];
              CmdArg   <= sr[38:7];
              CmdValid <= 1'b1;
              state    <= DELIVER;
            end
          end
        end
        DELIVER: begin
          if (CmdReady) begin
            CmdValid <= 1'b0;
            RspReady <= 1'b1;
            state    <= WAITRSP;
          end
        end
        WAITRSP: begin
          if (RspValid) begin
            RspReady <= 1'b0;
            if (RspNone) state <= IDLE;
            else begin
              tx    <= {rsp_hdr, rsp_crc, 1'b1};
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (ncr_cnt >= 7'(NCR_CYCLES)) begin
            state    <= SEND;
            CmdOutEn <= 1'b1;
            CmdOut   <= tx[47];
            tx       <= {tx[46:0], 1'b1};
            txcnt    <= 6'd1;
          end
        end
        SEND: begin
          if (txcnt == 6'd48) begin
            CmdOutEn <= 1'b0;
            CmdOut   <= 1'b1;
            state    <= IDLE;
          end else begin
            CmdOut <= tx[47];
            tx     <= {tx[46:0], 1'b1};
            txcnt  <= txcnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_cmd_responder.md
# sd_cmd_responder

Card-side SD command-line engine: deserialises 48-bit host commands from the CMD line, validates framing and CRC7, hands index/argument to card logic through a valid/ready handshake, then serialises the 48-bit response back onto CMD after the NCR gap. It is the card-end counterpart of the host command path and sits between the CMD pad (split in/out/enable) and the card state machine in the synthesizable card model.

## Interface
- NCR_CYCLES, 2: minimum clocks between command end bit and response start bit (2..64).
- Clk  in  1  SD clock; CMD sampled and driven on rising edge.
- Reset  in  1  synchronous, active-high.
- CmdIn  in  1  CMD line as seen by card (pull-up value 1 when idle).
- CmdOut  out  1  bit driven onto CMD.
- CmdOutEn  out  1  output enable for CMD pad.
- CmdValid  out  1  decoded command available.
- CmdReady  in  1  card logic accepts command.
- CmdIndex  out  6  command index.
- CmdArg  out  32  command argument.
- RspValid  in  1  response fields valid.
- RspReady  out  1  responder accepts response.
- RspNone  in  1  command needs no response; return to idle.
- RspNoCrc  in  1  send CRC field as 7'h7F (R3).
- RspIndex  in  6  response index field (6'h3F for R3).
- RspArg  in  32  response payload.
- CrcError  out  1  one-cycle pulse, bad command CRC.
- FrameError  out  1  one-cycle pulse, bad transmission or end bit.
- Busy  out  1  high in every state except Idle.

## Operation
- States: Idle, Recv, Deliver, WaitRsp, Gap, Send.
- Idle: CmdIn==0 sampled -> Recv, bit counter=1. CmdIn==1 -> stay.
- Recv: shift CmdIn MSB-first until 48 bits captured (bit 47 start ... bit 0 end). CRC7 (x^7+x^3+1, init 0) computed over bits 47..8.
- End of frame: transmission bit (46) must be 1 and end bit must be 1, else FrameError pulse, -> Idle. CRC mismatch -> CrcError pulse, -> Idle (see Configuration). Otherwise latch CmdIndex/CmdArg, -> Deliver.
- Deliver: CmdValid=1 until CmdValid&CmdReady; CmdIndex/CmdArg stable while CmdValid. -> WaitRsp.
- WaitRsp: RspReady=1. RspValid&RspNone -> Idle, no CMD drive. RspValid&!RspNone -> latch 48-bit frame {0,0,RspIndex,RspArg,crc7 or 7'h7F,1}, -> Gap.
- Gap: wait until NCR counter (started at cycle after end bit sampled, free-running through Deliver/WaitRsp) reaches NCR_CYCLES; if already reached, leave Gap next cycle. -> Send.
- Send: CmdOutEn=1 exactly 48 cycles, CmdOut = frame MSB first. After end bit -> Idle; CmdOutEn=0 next cycle.
- CmdIn ignored in all states except Idle and Recv.
- Response CRC7 computed over the 40 header/payload bits; when RspNoCrc, field is 7'h7F regardless.

## Timing
- Reset values: CmdOut=1, CmdOutEn=0, CmdValid=0, RspReady=0, CmdIndex=0, CmdArg=0, CrcError=0, FrameError=0, Busy=0, state Idle.
- Reset mid-operation (any state): all outputs to reset values at the next edge; partial frame discarded.
- CmdValid, CrcError or FrameError rise the cycle after the end bit is sampled.
- RspReady rises the cycle after the CmdValid handshake.
- Response start bit no earlier than NCR_CYCLES+1 edges after end-bit sample edge, and no earlier than two cycles after RspValid&RspReady.
- Back-to-back: next command start bit accepted the cycle after CmdOutEn falls.
- CmdValid held high indefinitely if CmdReady low; no timeout.

## Configuration
- SD_CMD_CRC_CHECK_EN defined: command CRC7 verified; mismatch drops frame with CrcError pulse.
- Undefined: CRC field captured but not checked; CrcError tied 0; any well-framed command delivered. Response CRC generation unaffected.

## Test plan
- CMD0 frame 48'h400000000095 -> CmdValid, CmdIndex=0, CmdArg=0; RspNone -> no CmdOutEn, Busy falls.
- CMD8 frame 48'h48000001AA87, reply RspIndex=8, RspArg=32'h1AA -> CMD carries 48'h08000001AA13, start bit NCR_CYCLES+1 edges after end bit.
- CMD0 with last byte 8'h97 -> CrcError pulse, no CmdValid (macro defined); with macro undefined -> CmdValid, index 0.
- Frame 48'h000000000095 (transmission bit 0) -> FrameError pulse, returns Idle, next valid CMD55 48'h770000000065 decoded index 55.
- R3 reply RspIndex=6'h3F, RspArg=32'h80FF8000, RspNoCrc=1 -> CMD carries 48'h3F80FF8000FF.
- Reset asserted at bit 20 of Send -> CmdOutEn=0, CmdOut=1 next edge; subsequent CMD0 decoded normally.
